// File: rtl/biquad_cascade.sv
// rtl/biquad_cascade.sv - N-stage Direct Form I biquad cascade built around one shared multiplier
// Define BIQUAD_COEF_SHADOW_EN to write coefficients into a shadow bank that coef_commit copies to the live bank.
module biquad_cascade #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_FRAC  = 14,
  parameter int N_STAGES   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  start,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  out_valid,
  input  logic [DATA_WIDTH-1:0] coef_in,
  input  logic [3:0]            coef_stage,
  input  logic [2:0]            coef_sel,
  input  logic                  coef_write,
  input  logic                  coef_commit
);

  localparam int AW = 2 * DATA_WIDTH + 4;
  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(N_STAGES - 1);
  localparam logic signed [AW-1:0] ACC_RND = AW'(longint'(1) <<< (COEF_FRAC - 1));
  localparam logic signed [AW-1:0] Y_MAX = AW'((longint'(1) <<< (DATA_WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] Y_MIN = AW'(-(longint'(1) <<< (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WB
  } state_t;

  state_t state, state_next;

  logic [SW-1:0]                stage;
  logic [2:0]                   k;
  logic signed [AW-1:0]         acc;
  logic signed [DATA_WIDTH-1:0] x_cur;
  logic signed [DATA_WIDTH-1:0] x1 [N_STAGES];
  logic signed [DATA_WIDTH-1:0] x2 [N_STAGES];
  logic signed [DATA_WIDTH-1:0] y1 [N_STAGES];
  logic signed [DATA_WIDTH-1:0] y2 [N_STAGES];
  logic signed [DATA_WIDTH-1:0] coef [N_STAGES][5];

  logic signed [DATA_WIDTH-1:0]   coef_val;
  logic signed [DATA_WIDTH-1:0]   op_val;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [AW-1:0]           prod_ext;
  logic signed [AW-1:0]           acc_sh;
  logic signed [DATA_WIDTH-1:0]   y_sat;

  assign ready = (state == IDLE);

  // Operand order k=0..4 pairs b0,b1,b2,a1,a2 with x0,x1,x2,y1,y2.
  always_comb begin
    coef_val = coef[stage][k];
    op_val   = '0;
    case (k)
      3'd0:    op_val = x_cur;
      3'd1:    op_val = x1[stage];
      3'd2:    op_val = x2[stage];
      3'd3:    op_val = y1[stage];
      3'd4:    op_val = y2[stage];
      default: op_val = '0;
    endcase
    prod     = coef_val * op_val;
    prod_ext = {{(AW - 2 * DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  end

  always_comb begin
    acc_sh = acc >>> COEF_FRAC;
    if (acc_sh > Y_MAX) begin
      y_sat = Y_MAX[DATA_WIDTH-1:0];
    end else if (acc_sh < Y_MIN) begin
      y_sat = Y_MIN[DATA_WIDTH-1:0];
    end else begin
      y_sat = acc_sh[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MAC;
      MAC:     if (k == 3'd4) state_next = WB;
      WB:      state_next = (stage == LAST_STAGE) ? IDLE : MAC;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      x_cur      <= '0;
      stage      <= '0;
      k          <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      for (int s = 0; s < N_STAGES; s++) begin
        x1[s] <= '0;
        x2[s] <= '0;
        y1[s] <= '0;
        y2[s] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_cur <= sample_in;
            stage <= '0;
            k     <= '0;
            acc   <= ACC_RND;
          end
        end
        MAC: begin
          if (k >= 3'd3) begin
            acc <= acc - prod_ext;
          end else begin
            acc <= acc + prod_ext;
          end
          k <= k + 3'd1;
        end
        WB: begin
          x2[stage] <= x1[stage];
          x1[stage] <= x_cur;
          y2[stage] <= y1[stage];
          y1[stage] <= y_sat;
          if (stage == LAST_STAGE) begin
            sample_out <= y_sat;
            out_valid  <= 1'b1;
          end else begin
            x_cur <= y_sat;
            stage <= stage + SW'(1);
            k     <= '0;
            acc   <= ACC_RND;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BIQUAD_COEF_SHADOW_EN
  logic signed [DATA_WIDTH-1:0] shadow [N_STAGES][5];
  logic                         commit_pending;

  // A commit seen while busy waits for IDLE so a sample never mixes banks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_pending <= 1'b0;
      for (int s = 0; s < N_STAGES; s++) begin
        for (int c = 0; c < 5; c++) begin
          coef[s][c]   <= '0;
          shadow[s][c] <= '0;
        end
      end
    end else begin
      for (int s = 0; s < N_STAGES; s++) begin
        for (int c = 0; c < 5; c++) begin
          if (coef_write && coef_stage == 4'(s) && coef_sel == 3'(c)) begin
            shadow[s][c] <= coef_in;
          end
        end
      end
      if (state == IDLE && (coef_commit || commit_pending)) begin
        commit_pending <= 1'b0;
        for (int s = 0; s < N_STAGES; s++) begin
          for (int c = 0; c < 5; c++) begin
            coef[s][c] <= shadow[s][c];
          end
        end
      end else if (coef_commit) begin
        commit_pending <= 1'b1;
      end
    end
  end
`else
  logic unused_commit;
  assign unused_commit = coef_commit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < N_STAGES; s++) begin
        for (int c = 0; c < 5; c++) begin
          coef[s][c] <= '0;
        end
      end
    end else begin
      for (int s = 0; s < N_STAGES; s++) begin
        for (int c = 0; c < 5; c++) begin
          if (coef_write && coef_stage == 4'(s) && coef_sel == 3'(c)) begin
            coef[s][c] <= coef_in;
          end
        end
      end
    end
  end
`endif

endmodule
